// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state encoding and opcode legality for the ALU arbiter
package alu_pkg;

   localparam logic [3:0] OP_ADD   = 4'd1;
   localparam logic [3:0] OP_ADD1  = 4'd2;
   localparam logic [3:0] OP_SUB   = 4'd3;
   localparam logic [3:0] OP_SUB1  = 4'd4;
   localparam logic [3:0] OP_MUL   = 4'd5;
   localparam logic [3:0] OP_FLOOR = 4'd7;
   localparam logic [3:0] OP_MOD   = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // Divide-type ops with a zero divisor never reach the ALU.
   function automatic logic op_ok(input logic [3:0] op, input logic b_zero);
      case (op)
         OP_ADD, OP_ADD1, OP_SUB, OP_SUB1, OP_MUL: op_ok = 1'b1;
         OP_FLOOR, OP_MOD:                         op_ok = !b_zero;
         default:                                  op_ok = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with priority pointer
module rr_arb2 (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       enable,
   input  logic [1:0] valid,
   output logic [1:0] grant
);

   logic ptr;

   always_comb begin
      grant = 2'b00;
      if (enable && !Reset) begin
         case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

   // A grant is always taken, so the pointer hands priority to the loser.
   always_ff @(posedge Clock) begin
      if (Reset)
         ptr <= 1'b0;
      else if (|grant)
         ptr <= grant[0];
   end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external ALU between two requesters, one op in flight
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             req0_valid,
   input  logic             req1_valid,
   input  logic [3:0]       req0_op,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req0_ready,
   output logic             req1_ready,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] alu_in_1,
   output logic [WIDTH-1:0] alu_in_2,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_z,
   input  logic             alu_y,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_z,
   output logic             rsp_y,
   output logic             rsp_err,
   output logic [15:0]      ops_done
);

   state_t           state, state_nxt;
   logic [1:0]       grant;
   logic             acc, acc_id, acc_ok;
   logic [3:0]       acc_op;
   logic [WIDTH-1:0] acc_a, acc_b;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             id_q;
   logic [15:0]      ops_cnt;

   rr_arb2 u_arb (
      .Clock  (Clock),
      .Reset  (Reset),
      .enable (state == ST_IDLE),
      .valid  ({req1_valid, req0_valid}),
      .grant  (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign acc        = |grant;
   assign acc_id     = grant[1];
   assign acc_op     = acc_id ? req1_op : req0_op;
   assign acc_a      = acc_id ? req1_a  : req0_a;
   assign acc_b      = acc_id ? req1_b  : req0_b;
   assign acc_ok     = op_ok(acc_op, acc_b == '0);

   assign alu_in_1 = a_q;
   assign alu_in_2 = b_q;
   assign ops_done = ops_cnt;

   always_comb begin
      state_nxt = state;
      alu_op    = 4'd0;
      rsp_valid = 1'b0;
      case (state)
         ST_IDLE:  if (acc) state_nxt = acc_ok ? ST_ISSUE : ST_RESP;
         ST_ISSUE: begin
            alu_op    = op_q;
            state_nxt = ST_WAIT;
         end
         ST_WAIT:  state_nxt = ST_RESP;
         ST_RESP:  begin
            rsp_valid = 1'b1;
            state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= ST_IDLE;
         op_q     <= 4'd0;
         a_q      <= '0;
         b_q      <= '0;
         id_q     <= 1'b0;
         rsp_id   <= 1'b0;
         rsp_data <= '0;
         rsp_z    <= 1'b0;
         rsp_y    <= 1'b0;
         rsp_err  <= 1'b0;
         ops_cnt  <= 16'd0;
      end else begin
         state <= state_nxt;
         if (acc) begin
            op_q <= acc_op;
            a_q  <= acc_a;
            b_q  <= acc_b;
            id_q <= acc_id;
            // Rejected ops skip the ALU and answer straight away.
            if (!acc_ok) begin
               rsp_id   <= acc_id;
               rsp_data <= '0;
               rsp_z    <= 1'b0;
               rsp_y    <= 1'b0;
               rsp_err  <= 1'b1;
            end
         end
         if (state == ST_WAIT) begin
            rsp_id   <= id_q;
            rsp_data <= alu_out;
            rsp_z    <= alu_z;
            rsp_y    <= alu_y;
            rsp_err  <= 1'b0;
         end
         if (state == ST_RESP && !rsp_err && ops_cnt != 16'hFFFF)
            ops_cnt <= ops_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural ALU and timing model
module tb_alu_arbiter;

   localparam int W = 16;

   logic         Clock = 1'b0;
   logic         Reset;
   logic         req0_valid, req1_valid;
   logic [3:0]   req0_op, req1_op;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         req0_ready, req1_ready;
   logic [3:0]   alu_op;
   logic [W-1:0] alu_in_1, alu_in_2, alu_out;
   logic         alu_z, alu_y;
   logic         rsp_valid, rsp_id, rsp_z, rsp_y, rsp_err;
   logic [W-1:0] rsp_data;
   logic [15:0]  ops_done;

   alu_arbiter #(.WIDTH(W)) dut (
      .Clock(Clock), .Reset(Reset),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_op(req0_op), .req1_op(req1_op),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .alu_op(alu_op), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
      .alu_out(alu_out), .alu_z(alu_z), .alu_y(alu_y),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_z(rsp_z), .rsp_y(rsp_y), .rsp_err(rsp_err),
      .ops_done(ops_done)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      bit           id;
      logic [W-1:0] data;
      bit           z;
      bit           y;
      bit           err;
      int           at;
   } exp_t;

   exp_t         q[$];
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   bit           run_mon = 0;
   int           free_edge = 0;
   bit           m_ptr = 0;
   int           m_ops = 0;
   int           issue_cyc = -1;
   logic [3:0]   issue_op = 4'd0;
   logic [W-1:0] issue_a = '0, issue_b = '0;

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h cycle=%0d", name, got, exp, cyc);
      end
   endtask

   function automatic bit legal(input logic [3:0] op, input logic [W-1:0] b);
      if (op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5}) return 1'b1;
      if (op == 4'd7 || op == 4'd8) return b != 0;
      return 1'b0;
   endfunction

   // {y, z, result}: y is the result parity, z flags a zero result
   function automatic logic [W+1:0] ref_rsp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      logic [W-1:0] one;
      one = 1;
      case (op)
         4'd1:    r = a + b;
         4'd2:    r = a + one;
         4'd3:    r = a - b;
         4'd4:    r = a - one;
         4'd5:    r = a * b;
         4'd7:    r = (b != 0) ? a / b : '0;
         4'd8:    r = (b != 0) ? a % b : '0;
         default: r = '0;
      endcase
      return {^r, r == '0, r};
   endfunction

   // External ALU: result available the cycle after the op is presented.
   always @(posedge Clock) begin
      if (alu_op != 4'd0) begin
         logic [W+1:0] r;
         r = ref_rsp(alu_op, alu_in_1, alu_in_2);
         alu_out <= r[W-1:0];
         alu_z   <= r[W];
         alu_y   <= r[W+1];
      end
   end

   always @(negedge Clock) begin
      if (run_mon) begin
         exp_t e;
         chk("alu_op", 64'(alu_op), 64'((cyc == issue_cyc) ? issue_op : 4'd0));
         if (cyc == issue_cyc)
            chk("alu_in", 64'({alu_in_1, alu_in_2}), 64'({issue_a, issue_b}));
         if (q.size() > 0 && q[0].at < cyc) begin
            e = q.pop_front();
            chk("rsp_missing", 64'(cyc), 64'(e.at));
         end
         if (rsp_valid) begin
            if (q.size() == 0)
               chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
            else begin
               e = q.pop_front();
               chk("rsp_time", 64'(cyc), 64'(e.at));
               chk("rsp_id", 64'(rsp_id), 64'(e.id));
               chk("rsp_data", 64'(rsp_data), 64'(e.data));
               chk("rsp_zyerr", 64'({rsp_z, rsp_y, rsp_err}), 64'({e.z, e.y, e.err}));
               chk("ops_done", 64'(ops_done), 64'(m_ops));
               if (!e.err && m_ops < 65535) m_ops++;
            end
         end
      end
   end

   task automatic drive(input bit rst,
                        input bit v0, input logic [3:0] o0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input bit v1, input logic [3:0] o1, input logic [W-1:0] a1, input logic [W-1:0] b1);
      logic [1:0]   g;
      logic [3:0]   op;
      logic [W-1:0] a, b;
      logic [W+1:0] r;
      int           n;
      bit           id;
      exp_t         e;
      @(negedge Clock);
      Reset = rst;
      req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
      #1;
      n = cyc + 1;
      g = 2'b00;
      if (!rst && n >= free_edge) begin
         if (v0 && v1) g = m_ptr ? 2'b10 : 2'b01;
         else          g = {v1, v0};
      end
      chk("ready", 64'({req1_ready, req0_ready}), 64'(g));
      if (rst) begin
         q.delete();
         free_edge = n + 1;
         m_ptr = 0;
         m_ops = 0;
         issue_cyc = -1;
      end else if (g != 2'b00) begin
         id = g[1];
         op = id ? o1 : o0;
         a  = id ? a1 : a0;
         b  = id ? b1 : b0;
         m_ptr = !id;
         e.id = id;
         if (legal(op, b)) begin
            r = ref_rsp(op, a, b);
            e.data = r[W-1:0]; e.z = r[W]; e.y = r[W+1]; e.err = 0; e.at = n + 2;
            issue_cyc = n; issue_op = op; issue_a = a; issue_b = b;
            free_edge = n + 4;
         end else begin
            e.data = '0; e.z = 0; e.y = 0; e.err = 1; e.at = n;
            free_edge = n + 2;
         end
         q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 4'd0, '0, '0, 0, 4'd0, '0, '0);
   endtask

   task automatic check_zero();
      @(negedge Clock);
      chk("reset_outputs",
          64'({req0_ready, req1_ready, alu_op, alu_in_1, alu_in_2, rsp_valid, rsp_id,
               rsp_data, rsp_z, rsp_y, rsp_err}), 64'(0));
      chk("reset_ops_done", 64'(ops_done), 64'(0));
   endtask

   function automatic logic [3:0] rnd_op();
      logic [3:0] ops [7];
      ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8};
      if ($urandom_range(0, 9) < 8) return ops[$urandom_range(0, 6)];
      return 4'($urandom_range(0, 15));
   endfunction

   function automatic logic [W-1:0] rnd_val();
      int k;
      k = $urandom_range(0, 5);
      if (k == 0) return '0;
      if (k < 3)  return W'($urandom_range(1, 9));
      return W'($urandom);
   endfunction

   initial begin
      Reset = 1'b1;
      req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
      req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
      alu_out = '0; alu_z = 0; alu_y = 0;

      drive(1, 1, 4'd1, 16'd1, 16'd1, 1, 4'd1, 16'd1, 16'd1);
      run_mon = 1;
      drive(1, 1, 4'd1, 16'd1, 16'd1, 1, 4'd1, 16'd1, 16'd1);
      check_zero();

      drive(0, 1, 4'd1, 16'd3, 16'd4, 0, 4'd0, '0, '0);
      idle(5);
      for (int i = 0; i < 12; i++) drive(0, 1, 4'd5, 16'd5, 16'd6, 1, 4'd2, 16'd9, 16'd0);
      idle(5);
      drive(0, 0, 4'd0, '0, '0, 1, 4'd7, 16'd8, 16'd0);
      idle(3);
      drive(0, 1, 4'd6, 16'd2, 16'd3, 0, 4'd0, '0, '0);
      idle(2);
      drive(0, 1, 4'd3, 16'd5, 16'd5, 0, 4'd0, '0, '0);
      idle(5);

      drive(0, 1, 4'd8, 16'd17, 16'd5, 0, 4'd0, '0, '0);
      idle(1);
      drive(1, 1, 4'd1, 16'd2, 16'd2, 1, 4'd1, 16'd3, 16'd3);
      check_zero();
      drive(0, 1, 4'd1, 16'd2, 16'd2, 1, 4'd1, 16'd3, 16'd3);
      idle(5);

      for (int i = 0; i < 1500; i++)
         drive(0, $urandom_range(0, 3) != 0, rnd_op(), rnd_val(), rnd_val(),
               $urandom_range(0, 3) != 0, rnd_op(), rnd_val(), rnd_val());
      idle(6);

      @(negedge Clock);
      force dut.ops_cnt = 16'hFFFD;
      #1 release dut.ops_cnt;
      m_ops = 65533;
      for (int i = 0; i < 16; i++) drive(0, 1, 4'd1, 16'd1, 16'd2, 1, 4'd2, 16'd7, 16'd0);
      idle(8);
      chk("ops_done_sat", 64'(ops_done), 64'(16'hFFFF));
      chk("queue_empty", 64'(q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, setting the operand/result width.
REQ-002 The block SHALL have port Clock  input  1  sole clock, all state updates on posedge.
REQ-003 The block SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have ports req0_valid/req1_valid  input  1 each  requester k presents an operation.
REQ-005 The block SHALL have ports req0_op/req1_op  input  4 each  requested ALU opcode.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands (a = data path A, b = data path B).
REQ-007 The block SHALL have ports req0_ready/req1_ready  output  1 each  request accepted this cycle when valid&ready.
REQ-008 The block SHALL have ports alu_op (output 4), alu_in_1/alu_in_2 (output WIDTH) driving the shared ALU.
REQ-009 The block SHALL have ports alu_out (input WIDTH), alu_z/alu_y (input 1) returned from the ALU.
REQ-010 The block SHALL have ports rsp_valid (output 1), rsp_id (output 1), rsp_data (output WIDTH), rsp_z/rsp_y/rsp_err (output 1) as the response bus.
REQ-011 The block SHALL have port ops_done  output  16  saturating count of completed non-error operations.

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; only IDLE accepts requests.
REQ-013 In IDLE, reqk_ready SHALL be 1 only for the granted requester; grant is decoded from state, valids and the priority pointer, with no path from alu_* inputs.
REQ-014 Arbitration SHALL be round-robin: one valid requester wins; both valid -> pointer wins; after acceptance the pointer moves to the other requester.
REQ-015 On acceptance the block SHALL latch op, a, b and requester id into holding registers and leave IDLE.
REQ-016 Legal opcodes SHALL be 1,2,3,4,5,7,8; an illegal opcode, or opcode 7/8 with b==0, SHALL go IDLE->RESP with rsp_err=1, rsp_data=0, rsp_z=0, rsp_y=0, and no ALU issue.
REQ-017 Legal path SHALL be IDLE->ISSUE->WAIT->RESP->IDLE, one cycle per state.
REQ-018 alu_op SHALL equal the latched opcode only in ISSUE and 0 in every other state; alu_in_1/alu_in_2 SHALL continuously drive the latched a/b.
REQ-019 At the end of WAIT the block SHALL register alu_out, alu_z, alu_y into rsp_data, rsp_z, rsp_y unmodified, with rsp_err=0.
REQ-020 rsp_valid SHALL be 1 for exactly the RESP cycle; rsp_id and rsp_* data SHALL hold their values until the next RESP.
REQ-021 Latency: handshake at edge T -> rsp_valid high in cycle T+3 (legal) or T+1 (error); throughput one op per 4 cycles.
REQ-022 The response SHALL not be backpressured; requesters sample it in the RESP cycle.
REQ-023 ops_done SHALL increment on each legal RESP and saturate at 16'hFFFF.
REQ-024 A request deasserted before acceptance SHALL be dropped silently; operands changing after acceptance SHALL not affect the in-flight operation.

Reset
REQ-025 Reset SHALL, in any state, force IDLE, pointer=0, alu_op=0, alu_in_1/alu_in_2=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_z=rsp_y=rsp_err=0, ops_done=0.
REQ-026 Reset mid-operation SHALL discard the in-flight operation with no response; Reset SHALL dominate simultaneous valid.
REQ-027 reqk_ready SHALL be 0 in any cycle where Reset is 1.

Structure
REQ-028 Opcode constants (ADD=1, ADD1=2, SUB=3, SUB1=4, MUL=5, FLOOR=7, MOD=8) and the FSM state encoding SHALL live in shared package alu_pkg.
REQ-029 Two-way round-robin grant logic with its pointer SHALL be sub-module rr_arb2; the ALU itself is external.

Verification
REQ-030 Req0 ADD a=3,b=4 alone -> req0_ready at T, alu_op=1 at T+1 only, rsp_valid at T+3 with rsp_id=0, rsp_data=7, ops_done=1.
REQ-031 Both valid every cycle, req0 MUL 5*6, req1 ADD1 9 -> grants alternate 0,1,0,...; responses 30 (id 0) then 10 (id 1), 4 cycles apart.
REQ-032 Req1 FLOOR a=8,b=0 -> rsp_valid at T+1, rsp_err=1, rsp_data=0, alu_op stays 0, ops_done unchanged.
REQ-033 Req0 opcode 6 -> rsp_err=1 at T+1; then req0 SUB a=5,b=5 -> rsp_z=1, rsp_data=0.
REQ-034 Reset asserted in WAIT of a MOD 17%5 -> no rsp_valid, all outputs 0 next cycle, following request granted to requester 0.
REQ-035 Preload ops_done near 16'hFFFF via 65535 ADDs (or force) -> further ops leave ops_done=16'hFFFF.
